// File: rtl/uart_reg_responder_if.sv
// Byte-level link between the UART core and the register responder.
// The master side is the UART (receiver strobes and transmitter status);
// the slave side is the responder that consumes bytes and requests transmits.
interface uart_reg_responder_if;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic [1:0] rx_error_bit;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;

  modport master (
    output rx_data,
    output rx_complete,
    output rx_error_bit,
    output tx_busy,
    input  tx_din,
    input  tx_wr_en
  );

  modport slave (
    input  rx_data,
    input  rx_complete,
    input  rx_error_bit,
    input  tx_busy,
    output tx_din,
    output tx_wr_en
  );
endinterface

// File: rtl/uart_reg_responder.sv
// Register-access command responder sitting behind a UART.
// Parses A5/CMD/ADDR/DATA/CHK frames, executes a read or write on a small
// register bank (register 0 is a fixed ID), and answers with a 5A/STATUS/
// RDATA/RCHK frame through the transmitter's one-cycle write handshake.
module uart_reg_responder #(
  parameter int         NUM_REGS       = 8,
  parameter logic [7:0] ID_VALUE       = 8'hC5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                  system_clk,
  input  logic                  reset_n,
  uart_reg_responder_if.slave   uart,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_GET_CMD  = 4'd1;
  localparam logic [3:0] ST_GET_ADDR = 4'd2;
  localparam logic [3:0] ST_GET_DATA = 4'd3;
  localparam logic [3:0] ST_GET_CHK  = 4'd4;
  localparam logic [3:0] ST_EXEC     = 4'd5;
  localparam logic [3:0] ST_TX_SEND  = 4'd6;
  localparam logic [3:0] ST_TX_GUARD = 4'd7;
  localparam logic [3:0] ST_TX_WAIT  = 4'd8;

  localparam logic [7:0] SOF_CMD   = 8'hA5;
  localparam logic [7:0] SOF_RESP  = 8'h5A;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_CHK = 8'h01;
  localparam logic [7:0] STAT_BAD_CMD = 8'h02;
  localparam logic [7:0] STAT_BAD_ADR = 8'h03;

  logic [3:0]      state;
  logic [7:0]      cmd_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [7:0]      chk_q;
  logic [7:0]      status_q;
  logic [7:0]      rdata_q;
  logic [2:0]      tx_idx;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      bank [1:NUM_REGS-1];

  logic [7:0] rd_val;
  logic       addr_oob;
  logic [7:0] status_c;
  logic [7:0] rdata_c;
  logic [7:0] tx_byte;
  logic       rx_clean;
  logic       rx_bad;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rx_clean = uart.rx_complete && (uart.rx_error_bit == 2'b00);
  assign rx_bad   = uart.rx_complete && (uart.rx_error_bit != 2'b00);
  assign addr_oob = ({1'b0, addr_q} >= 9'(NUM_REGS));

  // Expose the bank flat; slot 0 is the constant ID, the rest are storage
  assign regs_flat[7:0] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = bank[g];
  end

  // Read mux over the whole bank, including the ID slot
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) rd_val = regs_flat[8*i +: 8];
    end
  end

  // Status decode in priority order: checksum, command, address range
  always_comb begin
    status_c = STAT_OK;
    if (chk_q != (cmd_q ^ addr_q ^ data_q))
      status_c = STAT_BAD_CHK;
    else if ((cmd_q != CMD_WRITE) && (cmd_q != CMD_READ))
      status_c = STAT_BAD_CMD;
    else if (addr_oob || ((cmd_q == CMD_WRITE) && (addr_q == 8'h00)))
      status_c = STAT_BAD_ADR;
    rdata_c = 8'h00;
    if (status_c == STAT_OK)
      rdata_c = (cmd_q == CMD_WRITE) ? data_q : rd_val;
  end

  // Pick the response byte indexed by how many bytes have gone out
  always_comb begin
    case (tx_idx)
      3'd0:    tx_byte = SOF_RESP;
      3'd1:    tx_byte = status_q;
      3'd2:    tx_byte = rdata_q;
      default: tx_byte = status_q ^ rdata_q;
    endcase
  end

  // Register bank: only an accepted write in EXEC changes it
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) bank[i] <= 8'h00;
    end else if ((state == ST_EXEC) && (status_c == STAT_OK) && (cmd_q == CMD_WRITE)) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_q == 8'(i)) bank[i] <= data_q;
      end
    end
  end

  // Frame parser, executor and response transmitter
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cmd_q         <= 8'h00;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      chk_q         <= 8'h00;
      status_q      <= 8'h00;
      rdata_q       <= 8'h00;
      tx_idx        <= 3'd0;
      to_cnt        <= '0;
      busy          <= 1'b0;
      err_cnt       <= 8'h00;
      uart.tx_din   <= 8'h00;
      uart.tx_wr_en <= 1'b0;
    end else begin
      uart.tx_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (rx_clean && (uart.rx_data == SOF_CMD)) begin
            state <= ST_GET_CMD;
            busy  <= 1'b1;
          end
        end
        ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
          if (rx_bad) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            err_cnt <= sat_inc(err_cnt);
          end else if (rx_clean) begin
            to_cnt <= '0;
            case (state)
              ST_GET_CMD: begin
                cmd_q <= uart.rx_data;
                state <= ST_GET_ADDR;
              end
              ST_GET_ADDR: begin
                addr_q <= uart.rx_data;
                state  <= ST_GET_DATA;
              end
              ST_GET_DATA: begin
                data_q <= uart.rx_data;
                state  <= ST_GET_CHK;
              end
              default: begin
                chk_q <= uart.rx_data;
                state <= ST_EXEC;
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_EXEC: begin
          status_q <= status_c;
          rdata_q  <= rdata_c;
          if (status_c != STAT_OK) err_cnt <= sat_inc(err_cnt);
          if (!uart.tx_busy) begin
            uart.tx_din   <= SOF_RESP;
            uart.tx_wr_en <= 1'b1;
            tx_idx        <= 3'd1;
            state         <= ST_TX_SEND;
          end else begin
            tx_idx <= 3'd0;
            state  <= ST_TX_WAIT;
          end
        end
        ST_TX_SEND: begin
          state <= ST_TX_GUARD;
        end
        ST_TX_GUARD: begin
          state <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (!uart.tx_busy) begin
            if (tx_idx == 3'd4) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              uart.tx_din   <= tx_byte;
              uart.tx_wr_en <= 1'b1;
              tx_idx        <= tx_idx + 3'd1;
              state         <= ST_TX_SEND;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: directed frames from the
// command protocol plus randomized frames, all checked against a
// register-map model that computes status and read data from the rules.
module tb_uart_reg_responder;
  localparam int         NREGS = 8;
  localparam logic [7:0] ID    = 8'hC5;
  localparam int         TMO   = 300;

  logic               system_clk = 1'b0;
  logic               reset_n;
  logic [8*NREGS-1:0] regs_flat;
  logic               busy;
  logic [7:0]         err_cnt;

  uart_reg_responder_if u_if ();

  uart_reg_responder #(
    .NUM_REGS       (NREGS),
    .ID_VALUE       (ID),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .system_clk (system_clk),
    .reset_n    (reset_n),
    .uart       (u_if),
    .regs_flat  (regs_flat),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 system_clk = ~system_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_hold = 0;
  int         busy_left = 0;
  int         viol = 0;
  logic       last_wr = 1'b0;
  logic [7:0] tx_q [$];
  logic [7:0] mdl_regs [NREGS];
  int         mdl_err = 0;

  // Transmitter model: records each write pulse, flags pulses issued
  // while busy or lasting more than one cycle, and holds busy afterwards
  always @(negedge system_clk) begin
    if (u_if.tx_wr_en) begin
      if (u_if.tx_busy) viol++;
      if (last_wr) viol++;
      tx_q.push_back(u_if.tx_din);
      busy_left = busy_hold;
    end
    last_wr = u_if.tx_wr_en;
    u_if.tx_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one received byte for a single cycle, then idle for gap cycles
  task automatic apply_stimulus(input logic [7:0] b, input logic [1:0] e, input int gap);
    u_if.rx_data      = b;
    u_if.rx_error_bit = e;
    u_if.rx_complete  = 1'b1;
    @(negedge system_clk);
    u_if.rx_complete  = 1'b0;
    u_if.rx_error_bit = 2'b00;
    repeat (gap) @(negedge system_clk);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) mdl_regs[i] = 8'h00;
    mdl_err = 0;
  endfunction

  function automatic logic [63:0] exp_flat();
    logic [63:0] f = '0;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = (i == 0) ? ID : mdl_regs[i];
    return f;
  endfunction

  // Reference behaviour of one complete command frame
  function automatic logic [31:0] model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                              input logic [7:0] data, input logic [7:0] chk);
    logic [7:0] st;
    logic [7:0] rd = 8'h00;
    int a = int'(addr);
    if (chk != (cmd ^ addr ^ data)) st = 8'h01;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
    else if (a >= NREGS || (cmd == 8'h01 && a == 0)) st = 8'h03;
    else st = 8'h00;
    if (st == 8'h00) begin
      if (cmd == 8'h01) begin
        mdl_regs[a] = data;
        rd = data;
      end else begin
        rd = (a == 0) ? ID : mdl_regs[a];
      end
    end else begin
      mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
    end
    return {8'h5A, st, rd, st ^ rd};
  endfunction

  function automatic void model_abort();
    mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
  endfunction

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] chk, input int gap_max);
    apply_stimulus(8'hA5, 2'b00, $urandom_range(0, gap_max));
    apply_stimulus(cmd,   2'b00, $urandom_range(0, gap_max));
    apply_stimulus(addr,  2'b00, $urandom_range(0, gap_max));
    apply_stimulus(data,  2'b00, $urandom_range(0, gap_max));
    apply_stimulus(chk,   2'b00, 0);
  endtask

  // Wait for four response bytes and busy low; optionally inject stray
  // A5 bytes while the response is still in progress
  task automatic wait_response(input bit stray);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 6000) begin
      @(negedge system_clk);
      cyc++;
      u_if.rx_complete  = 1'b0;
      u_if.rx_error_bit = 2'b00;
      if (tx_q.size() >= 4 && !busy) done = 1'b1;
      else if (stray && tx_q.size() < 3 && $urandom_range(0, 15) == 0) begin
        u_if.rx_data     = 8'hA5;
        u_if.rx_complete = 1'b1;
      end
    end
    u_if.rx_complete = 1'b0;
    check_output("resp_wait_done", 64'(done), 64'd1);
  endtask

  task automatic finish_frame(input string tag, input logic [31:0] resp, input bit stray);
    logic [31:0] obs = '0;
    wait_response(stray);
    repeat (4) @(negedge system_clk);
    check_output($sformatf("%s_nbytes", tag), 64'(tx_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < tx_q.size(); i++) obs[31-8*i -: 8] = tx_q[i];
    check_output($sformatf("%s_resp", tag), 64'(obs), 64'(resp));
    check_output($sformatf("%s_errcnt", tag), 64'(err_cnt), 64'(mdl_err));
    check_output($sformatf("%s_regs", tag), 64'(regs_flat), exp_flat());
    check_output($sformatf("%s_busy", tag), 64'(busy), 64'd0);
    check_output($sformatf("%s_hs", tag), 64'(viol), 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] chk,
                             input int gap_max, input bit stray);
    logic [31:0] resp;
    tx_q.delete();
    resp = model_frame(cmd, addr, data, chk);
    send_frame(cmd, addr, data, chk, gap_max);
    finish_frame(tag, resp, stray);
  endtask

  // Main test sequence
  initial begin
    logic [31:0] resp;
    int sz;
    reset_n           = 1'b0;
    u_if.rx_data      = 8'h00;
    u_if.rx_complete  = 1'b0;
    u_if.rx_error_bit = 2'b00;
    model_reset();
    repeat (3) @(negedge system_clk);

    check_output("rst_tx_din", 64'(u_if.tx_din), 64'h00);
    check_output("rst_tx_wr_en", 64'(u_if.tx_wr_en), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_output("rst_regs", 64'(regs_flat), exp_flat());
    reset_n = 1'b1;
    repeat (2) @(negedge system_clk);

    $display("[TB] write reg 3 with latency checks");
    tx_q.delete();
    resp = model_frame(8'h01, 8'h03, 8'h3C, 8'h3E);
    check_output("busy_before_sof", 64'(busy), 64'd0);
    apply_stimulus(8'hA5, 2'b00, 0);
    check_output("busy_after_sof", 64'(busy), 64'd1);
    apply_stimulus(8'h01, 2'b00, 0);
    apply_stimulus(8'h03, 2'b00, 0);
    apply_stimulus(8'h3C, 2'b00, 0);
    apply_stimulus(8'h3E, 2'b00, 0);
    check_output("n1_reg3_old", 64'(regs_flat[31:24]), 64'h00);
    check_output("n1_wr_en", 64'(u_if.tx_wr_en), 64'd0);
    @(negedge system_clk);
    check_output("n2_reg3_new", 64'(regs_flat[31:24]), 64'h3C);
    check_output("n2_wr_en", 64'(u_if.tx_wr_en), 64'd1);
    check_output("n2_tx_din", 64'(u_if.tx_din), 64'h5A);
    finish_frame("wr3", resp, 1'b0);

    $display("[TB] reads and error frames");
    check_frame("rd3", 8'h02, 8'h03, 8'h00, 8'h01, 0, 1'b0);
    check_frame("rd0", 8'h02, 8'h00, 8'h00, 8'h02, 1, 1'b0);
    check_frame("badchk", 8'h02, 8'h03, 8'h00, 8'hFF, 0, 1'b0);
    check_frame("badaddr", 8'h01, 8'h09, 8'h11, 8'h19, 0, 1'b0);
    check_frame("wr0", 8'h01, 8'h00, 8'h55, 8'h54, 2, 1'b0);
    check_frame("rd0_again", 8'h02, 8'h00, 8'h00, 8'h02, 0, 1'b0);
    check_output("errcnt_three", 64'(err_cnt), 64'd3);

    $display("[TB] inter-byte timeout");
    tx_q.delete();
    apply_stimulus(8'hA5, 2'b00, 0);
    apply_stimulus(8'h01, 2'b00, 0);
    repeat (TMO - 2) @(negedge system_clk);
    check_output("tmo_before_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge system_clk);
    model_abort();
    check_output("tmo_after_busy", 64'(busy), 64'd0);
    check_output("tmo_errcnt", 64'(err_cnt), 64'(mdl_err));
    repeat (20) @(negedge system_clk);
    check_output("tmo_no_tx", 64'(tx_q.size()), 64'd0);
    check_frame("post_tmo", 8'h01, 8'h02, 8'hA7, 8'hA4, 1, 1'b0);

    $display("[TB] byte just inside the timeout window");
    tx_q.delete();
    resp = model_frame(8'h01, 8'h03, 8'h5A, 8'h58);
    apply_stimulus(8'hA5, 2'b00, 0);
    apply_stimulus(8'h01, 2'b00, TMO - 2);
    apply_stimulus(8'h03, 2'b00, 0);
    apply_stimulus(8'h5A, 2'b00, 0);
    apply_stimulus(8'h58, 2'b00, 0);
    finish_frame("tmo_edge", resp, 1'b0);

    $display("[TB] error byte abort");
    tx_q.delete();
    apply_stimulus(8'hA5, 2'b00, 0);
    apply_stimulus(8'h01, 2'b00, 0);
    apply_stimulus(8'h03, 2'b00, 0);
    apply_stimulus(8'h77, 2'b01, 30);
    model_abort();
    check_output("rxerr_no_tx", 64'(tx_q.size()), 64'd0);
    check_output("rxerr_errcnt", 64'(err_cnt), 64'(mdl_err));
    check_output("rxerr_busy", 64'(busy), 64'd0);
    check_frame("post_rxerr", 8'h02, 8'h03, 8'h00, 8'h01, 0, 1'b0);

    $display("[TB] slow transmitter with stray bytes");
    busy_hold = 500;
    check_frame("slow_tx", 8'h02, 8'h03, 8'h11, 8'h10, 0, 1'b1);
    busy_hold = 0;

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      logic [7:0] c, a, d, k;
      int r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, NREGS + 1));
      d = 8'($urandom_range(0, 255));
      k = c ^ a ^ d;
      if ($urandom_range(0, 5) == 0) k = k ^ 8'($urandom_range(1, 255));
      busy_hold = $urandom_range(0, 8);
      check_frame($sformatf("rnd%0d", n), c, a, d, k, 2, 1'($urandom_range(0, 1)));
    end
    busy_hold = 0;

    $display("[TB] error counter saturation");
    for (int n = 0; n < 260; n++) begin
      if (n % 2 == 0) begin
        tx_q.delete();
        resp = model_frame(8'h02, 8'h01, 8'h00, 8'h00);
        send_frame(8'h02, 8'h01, 8'h00, 8'h00, 0);
        wait_response(1'b0);
      end else begin
        apply_stimulus(8'hA5, 2'b00, 0);
        apply_stimulus(8'h33, 2'b10, 1);
        model_abort();
      end
    end
    check_output("sat_errcnt", 64'(err_cnt), 64'(mdl_err));
    check_output("sat_errcnt_255", 64'(err_cnt), 64'd255);

    $display("[TB] reset during response");
    busy_hold = 20;
    tx_q.delete();
    resp = model_frame(8'h01, 8'h05, 8'h99, 8'h9D);
    send_frame(8'h01, 8'h05, 8'h99, 8'h9D, 0);
    for (int cyc = 0; cyc < 2000 && tx_q.size() < 2; cyc++) @(negedge system_clk);
    check_output("rst_mid_progress", 64'(tx_q.size() >= 2), 64'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_output("arst_tx_wr_en", 64'(u_if.tx_wr_en), 64'd0);
    check_output("arst_tx_din", 64'(u_if.tx_din), 64'h00);
    check_output("arst_busy", 64'(busy), 64'd0);
    check_output("arst_err_cnt", 64'(err_cnt), 64'd0);
    check_output("arst_regs", 64'(regs_flat), exp_flat());
    sz = tx_q.size();
    repeat (3) @(negedge system_clk);
    reset_n = 1'b1;
    repeat (200) @(negedge system_clk);
    check_output("arst_no_more_tx", 64'(tx_q.size()), 64'(sz));
    check_output("arst_busy_after", 64'(busy), 64'd0);
    busy_hold = 0;
    check_frame("post_rst", 8'h02, 8'h00, 8'h00, 8'h02, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Command responder on the far end of the UART link: it consumes received bytes from the UART receiver and parses host command frames. It executes register reads and writes on an internal register bank, then returns a response frame through the UART transmitter's `din`/`wr_en`/`tx_busy` handshake. It sits beside the UART top in the same `system_clk` domain and gives software a minimal register-access protocol over the serial port. The link is half-duplex: the host sends one command frame, then waits for the response.

## Interface
- `NUM_REGS`, 8: registers in bank, 2..256; address 0 is read-only ID.
- `ID_VALUE`, 8'hC5: value returned for register 0.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles between bytes inside a frame.
- `system_clk`  in  1  sole clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid while `rx_complete`=1.
- `rx_complete`  in  1  one-cycle pulse per received byte.
- `rx_error_bit`  in  2  receiver error flags, sampled with `rx_complete`; nonzero means bad byte.
- `tx_din`  out  8  byte to transmit.
- `tx_wr_en`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy.
- `regs_flat`  out  8*NUM_REGS  register bank, reg i at bits [8i+7:8i]; reg 0 slice = `ID_VALUE`.
- `busy`  out  1  high from the first frame byte until the response completes.
- `err_cnt`  out  8  count of rejected or aborted frames, saturating at 255.

## Operation
- Command frame: `A5`, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA. CMD `01` = write, `02` = read (DATA is ignored for a read but still covered by CHK).
- Response frame: `5A`, STATUS, RDATA, RCHK, with RCHK = STATUS^RDATA.
- STATUS codes, checked in priority order: `01` bad checksum, `02` unknown CMD, `03` ADDR ≥ NUM_REGS or a write to ADDR 0, `00` OK.
- RDATA is the register value on an OK read, the written DATA on an OK write, and `00` on any error.
- States: IDLE → GET_CMD → GET_ADDR → GET_DATA → GET_CHK → EXEC → TX_SEND → TX_GUARD → TX_WAIT → (TX_SEND for the next byte | IDLE after byte 3).
- IDLE: a clean byte `A5` goes to GET_CMD. Any other byte, including error bytes, is dropped silently.
- GET_*: each clean byte is latched and advances the state.
- A byte with `rx_error_bit`≠0 while in GET_*: abort to IDLE, `err_cnt`+1, no response.
- Inter-byte timeout: a counter clears on every accepted byte and counts in GET_*. When it reaches TIMEOUT_CYCLES: abort to IDLE, `err_cnt`+1, no response.
- EXEC: compute STATUS. An OK write updates the register. A non-OK STATUS increments `err_cnt`.
- Bytes received in EXEC or TX_* are ignored (half-duplex) and do not count as errors.
- `err_cnt` holds at 255.
- Reset mid-frame or mid-response: all state clears immediately. Any byte already handed to the transmitter completes on the line; no further bytes are issued.

## Timing
- Reset values: `tx_din`=00, `tx_wr_en`=0, `busy`=0, `err_cnt`=00, regs 1..NUM_REGS-1 = 00, state IDLE, timeout counter 0.
- `busy` rises the cycle after the `A5` pulse. It falls the cycle after `tx_busy` is sampled low in TX_WAIT following response byte 3.
- If the CHK byte's `rx_complete` arrives at cycle N: EXEC runs at N+1. A register write is visible on `regs_flat` at N+2. The first `tx_wr_en` occurs at N+2, provided `tx_busy`=0 at N+1.
- Transmit handshake:
  - `tx_wr_en` is high for exactly one cycle, with `tx_din` stable in that cycle.
  - The cycle after the pulse is TX_GUARD, where `tx_busy` is ignored.
  - From the following cycle, the next pulse is issued in the first cycle in which `tx_busy` is sampled low.
  - `tx_wr_en` is never asserted while `tx_busy`=1.
- Timeout abort fires exactly TIMEOUT_CYCLES cycles after the last accepted byte's pulse.
- Bytes arriving back-to-back on consecutive `rx_complete` pulses must all be accepted with no loss.

## Test plan
- Write reg 3: send `A5 01 03 3C 3E` → `regs_flat[31:24]`=3C at N+2; response `5A 00 3C 3C`; `err_cnt`=0; `busy` low after the last byte.
- Read reg 3 after the write: `A5 02 03 00 01` → `5A 00 3C 3C`. Read reg 0: `A5 02 00 00 02` → `5A 00 C5 C5`.
- Errors:
  - Bad checksum `A5 02 03 00 FF` → `5A 01 00 01`.
  - Bad address `A5 01 09 11 19` (NUM_REGS=8) → `5A 03 00 03`.
  - Write to reg 0 `A5 01 00 55 54` → `5A 03 00 03`; reg 0 still reads C5.
  - Result: `err_cnt`=3.
- Aborts:
  - `A5 01` then silence for TIMEOUT_CYCLES → no `tx_wr_en`, `err_cnt`+1, and the next valid frame succeeds.
  - `A5 01 03` followed by a byte with `rx_error_bit`=2'b01 → abort, `err_cnt`+1.
- Handshake: hold `tx_busy` high for 500 cycles after each pulse → exactly 4 pulses, none while busy. Stray `A5` bytes injected mid-response → ignored.
- Saturation and reset:
  - 260 bad frames → `err_cnt`=255.
  - Deassert `reset_n` mid-response → all outputs return to reset values asynchronously; no further pulses.
